// File: rtl/box_controlling_module.sv
// Push-button bounding-box controller: move/resize a box in image pixel space with auto-repeat.
// Define DEBOUNCE_EN to insert a stable-time counter filter behind each button synchroniser.
module box_controlling_module #(
    parameter int IMAGE_WIDTH     = 1080,
    parameter int IMAGE_HEIGHT    = 1920,
    parameter int BOX_INIT        = 128,
    parameter int MIN_SIZE        = 16,
    parameter int STEP            = 8,
    parameter int REPEAT_CYCLES   = 2_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_sel,
    input  logic        button_left,
    input  logic        button_right,
    input  logic        button_up,
    input  logic        button_down,
    input  logic        button_bigger,
    input  logic        button_smaller,
    output logic [10:0] x1,
    output logic [10:0] y1,
    output logic [10:0] x2,
    output logic [10:0] y2
);

    typedef logic [10:0]        pix_t;
    typedef logic signed [11:0] coord_t;
    typedef struct packed { pix_t lo; pix_t hi; } span_t;

    localparam pix_t   XMAX       = pix_t'(IMAGE_WIDTH - 1);
    localparam pix_t   YMAX       = pix_t'(IMAGE_HEIGHT - 1);
    localparam pix_t   X_INIT     = pix_t'((IMAGE_WIDTH - BOX_INIT) / 2);
    localparam pix_t   Y_INIT     = pix_t'((IMAGE_HEIGHT - BOX_INIT) / 2);
    localparam pix_t   SIDE_M1    = pix_t'(BOX_INIT - 1);
    localparam coord_t STEP_S     = coord_t'(STEP);
    localparam pix_t   STEP_P     = pix_t'(STEP);
    localparam pix_t   MIN_M1     = pix_t'(MIN_SIZE - 1);
    localparam pix_t   SHRINK_MIN = pix_t'(MIN_SIZE + 2 * STEP - 1);
    localparam logic [5:0] MOVE_MASK   = 6'b001111;
    localparam logic [5:0] RESIZE_MASK = 6'b110000;
    localparam int TW = $clog2(REPEAT_CYCLES + 1);

`ifdef DEBOUNCE_EN
    localparam int FILTER_LEN = DEBOUNCE_CYCLES;
`else
    localparam int FILTER_LEN = 0 * DEBOUNCE_CYCLES;
`endif
    // Edges are ignored until synchronisers (and filters) have refilled after reset.
    localparam int SETTLE = FILTER_LEN + 4;
    localparam int SW     = $clog2(SETTLE + 1);

    function automatic coord_t ext(input pix_t p);
        return coord_t'({1'b0, p});
    endfunction

    function automatic pix_t sat(input coord_t v, input pix_t lim);
        if (v < 0) return '0;
        if (v > ext(lim)) return lim;
        return pix_t'(v);
    endfunction

    function automatic span_t move_axis(input span_t s, input logic dec, input logic inc, input pix_t lim);
        span_t r;
        r = s;
        if (inc && !dec) begin
            r.hi = sat(ext(s.hi) + STEP_S, lim);
            r.lo = r.hi - (s.hi - s.lo);
        end else if (dec && !inc) begin
            r.lo = sat(ext(s.lo) - STEP_S, lim);
            r.hi = r.lo + (s.hi - s.lo);
        end
        return r;
    endfunction

    function automatic span_t resize_axis(input span_t s, input logic grow, input logic shrink, input pix_t lim);
        span_t r;
        r = s;
        if (grow && !shrink) begin
            r.lo = sat(ext(s.lo) - STEP_S, lim);
            r.hi = sat(ext(s.hi) + STEP_S, lim);
        end else if (shrink && !grow) begin
            if (s.hi - s.lo >= SHRINK_MIN) begin
                r.lo = s.lo + STEP_P;
                r.hi = s.hi - STEP_P;
            end else begin
                r.lo = s.lo + ((s.hi - s.lo - MIN_M1) >> 1);
                r.hi = r.lo + MIN_M1;
            end
        end
        return r;
    endfunction

    // Stage p0/p1: two-flop synchronisers; bit order left,right,up,down,bigger,smaller
    logic [5:0] btn_raw, btn_p0, btn_p1, btn_flt;
    logic       mode_p0, mode_p1;

    assign btn_raw = {button_smaller, button_bigger, button_down, button_up, button_right, button_left};

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0  <= '0;
            btn_p1  <= '0;
            mode_p0 <= 1'b0;
            mode_p1 <= 1'b0;
        end else begin
            btn_p0  <= btn_raw;
            btn_p1  <= btn_p0;
            mode_p0 <= mode_sel;
            mode_p1 <= mode_p0;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] db_cnt [6];

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_flt <= '0;
            for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (btn_p1[i] == btn_flt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_flt[i] <= btn_p1[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign btn_flt = btn_p1;
`endif

    // Step trigger: rising edge of an active button, then every REPEAT_CYCLES while held
    logic [5:0]    btn_prev, mask, active;
    logic          mode_prev, hold_ok, rise, mode_chg, repeat_hit, settling, step;
    logic [TW-1:0] rpt_cnt;
    logic [SW-1:0] settle_cnt;

    assign mask       = mode_p1 ? RESIZE_MASK : MOVE_MASK;
    assign active     = btn_flt & mask;
    assign rise       = |(btn_flt & ~btn_prev & mask);
    assign mode_chg   = mode_p1 != mode_prev;
    assign settling   = settle_cnt != SW'(SETTLE);
    assign repeat_hit = hold_ok && (rpt_cnt == TW'(REPEAT_CYCLES - 1));
    assign step       = !settling && !mode_chg && (rise || repeat_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev   <= '1;
            mode_prev  <= 1'b0;
            hold_ok    <= 1'b0;
            rpt_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            mode_prev <= mode_p1;
            if (settling) begin
                settle_cnt <= settle_cnt + 1'b1;
                btn_prev   <= '1;
                hold_ok    <= 1'b0;
                rpt_cnt    <= '0;
            end else begin
                btn_prev <= btn_flt;
                if (mode_chg || active == '0) begin
                    hold_ok <= 1'b0;
                    rpt_cnt <= '0;
                end else if (rise) begin
                    hold_ok <= 1'b1;
                    rpt_cnt <= '0;
                end else if (repeat_hit) begin
                    rpt_cnt <= '0;
                end else if (hold_ok) begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end
        end
    end

    // Box update: next corners computed combinationally, registered on step
    span_t cur_x, cur_y, nxt_x, nxt_y;

    assign cur_x = '{x1, x2};
    assign cur_y = '{y1, y2};

    always_comb begin
        nxt_x = cur_x;
        nxt_y = cur_y;
        if (step) begin
            if (mode_p1) begin
                nxt_x = resize_axis(cur_x, btn_flt[4], btn_flt[5], XMAX);
                nxt_y = resize_axis(cur_y, btn_flt[4], btn_flt[5], YMAX);
            end else begin
                nxt_x = move_axis(cur_x, btn_flt[0], btn_flt[1], XMAX);
                nxt_y = move_axis(cur_y, btn_flt[2], btn_flt[3], YMAX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1 <= X_INIT;
            x2 <= X_INIT + SIDE_M1;
            y1 <= Y_INIT;
            y2 <= Y_INIT + SIDE_M1;
        end else begin
            x1 <= nxt_x.lo;
            x2 <= nxt_x.hi;
            y1 <= nxt_y.lo;
            y2 <= nxt_y.hi;
        end
    end

endmodule

// File: tb/tb_box_controlling_module.sv
// Bench for box_controlling_module: directed scenarios plus randomized button holds vs. a reference model.
module tb_box_controlling_module;

    localparam int R = 20;
    localparam int W = 1080;
    localparam int H = 1920;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_sel = 1'b0;
    logic        button_left = 1'b0, button_right = 1'b0, button_up = 1'b0;
    logic        button_down = 1'b0, button_bigger = 1'b0, button_smaller = 1'b0;
    logic [10:0] x1, y1, x2, y2;

    box_controlling_module #(.REPEAT_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .mode_sel(mode_sel),
        .button_left(button_left), .button_right(button_right),
        .button_up(button_up), .button_down(button_down),
        .button_bigger(button_bigger), .button_smaller(button_smaller),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mx1, my1, mx2, my2, mmode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_box(input string tag, input int a1, input int b1, input int a2, input int b2);
        check({tag, ".x1"}, 32'(x1), a1);
        check({tag, ".y1"}, 32'(y1), b1);
        check({tag, ".x2"}, 32'(x2), a2);
        check({tag, ".y2"}, 32'(y2), b2);
    endtask

    task automatic model_reset();
        mx1 = 476; mx2 = 603; my1 = 896; my2 = 1023;
    endtask

    task automatic shrink_axis(inout int lo, inout int hi);
        int c2;
        if ((hi - lo + 1) - 16 >= 16) begin
            lo += 8; hi -= 8;
        end else begin
            c2 = lo + hi;
            lo = (c2 - 15) / 2;
            hi = lo + 15;
        end
    endtask

    // Reference rules; mask bits: 0 left,1 right,2 up,3 down,4 bigger,5 smaller
    task automatic model_step(input logic [5:0] m);
        int d, sh;
        if (mmode == 0) begin
            d = int'(m[1]) - int'(m[0]);
            if (d > 0) begin sh = (W - 1 - mx2 < 8) ? W - 1 - mx2 : 8; mx1 += sh; mx2 += sh; end
            if (d < 0) begin sh = (mx1 < 8) ? mx1 : 8; mx1 -= sh; mx2 -= sh; end
            d = int'(m[3]) - int'(m[2]);
            if (d > 0) begin sh = (H - 1 - my2 < 8) ? H - 1 - my2 : 8; my1 += sh; my2 += sh; end
            if (d < 0) begin sh = (my1 < 8) ? my1 : 8; my1 -= sh; my2 -= sh; end
        end else if (m[4] && !m[5]) begin
            mx1 = (mx1 - 8 < 0) ? 0 : mx1 - 8;
            my1 = (my1 - 8 < 0) ? 0 : my1 - 8;
            mx2 = (mx2 + 8 > W - 1) ? W - 1 : mx2 + 8;
            my2 = (my2 + 8 > H - 1) ? H - 1 : my2 + 8;
        end else if (m[5] && !m[4]) begin
            shrink_axis(mx1, mx2);
            shrink_axis(my1, my2);
        end
    endtask

    task automatic drive(input logic [5:0] m);
        {button_smaller, button_bigger, button_down, button_up, button_right, button_left} = m;
    endtask

    task automatic press(input logic [5:0] m, input int cycles);
        @(negedge clk);
        drive(m);
        repeat (cycles) @(negedge clk);
        drive(6'b0);
        repeat (6) @(negedge clk);
    endtask

    task automatic set_mode(input int m);
        @(negedge clk);
        mode_sel = (m != 0);
        mmode = m;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        model_reset();
    endtask

    initial begin
        logic [5:0] m;
        int n, steps;
        mmode = 0;
        do_reset();
        check_box("reset", 476, 896, 603, 1023);

        press(6'b000010, 2 * R + R / 2);
        check_box("move_right_3", 500, 896, 627, 1023);

        do_reset();
        press(6'b000100, 7 * R + R / 2);
        check_box("move_up_8", 476, 832, 603, 959);

        do_reset();
        press(6'b000001, 80 * R + R / 2);
        check_box("left_clamp", 0, 896, 127, 1023);

        do_reset();
        set_mode(1);
        press(6'b011001, 2 * R + R / 2);
        check_box("bigger_3", 452, 872, 627, 1047);

        do_reset();
        press(6'b100000, 20 * R + R / 2);
        check_box("smaller_min", 532, 952, 547, 967);

        set_mode(0);
        do_reset();
        @(negedge clk);
        button_right = 1'b1;
        repeat (R / 2) @(negedge clk);
        check("hold_first_step.x1", 32'(x1), 484);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_box("rst_mid_hold", 476, 896, 603, 1023);
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * R) @(negedge clk);
        check_box("held_after_rst", 476, 896, 603, 1023);
        drive(6'b0);
        repeat (6) @(negedge clk);
        press(6'b000010, R / 2);
        check_box("repress_after_rst", 484, 896, 611, 1023);

        do_reset();
        @(negedge clk);
        button_bigger = 1'b1;
        repeat (10) @(negedge clk);
        mode_sel = 1'b1;
        mmode = 1;
        repeat (3 * R) @(negedge clk);
        check_box("held_across_mode", 476, 896, 603, 1023);
        drive(6'b0);
        repeat (6) @(negedge clk);
        press(6'b010000, R / 2);
        check_box("repress_bigger", 468, 888, 611, 1031);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            set_mode(int'($urandom_range(0, 1)));
            m = 6'($urandom_range(1, 63));
            n = ($urandom_range(0, 7) == 0) ? 60 : int'($urandom_range(0, 4));
            press(m, n * R + R / 2);
            steps = ((m & ((mmode != 0) ? 6'b110000 : 6'b001111)) != 6'b0) ? n + 1 : 0;
            repeat (steps) model_step(m);
            check_box($sformatf("rand%0d", i), mx1, my1, mx2, my2);
            check($sformatf("rand%0d.xorder", i), 32'(x1 < x2), 1);
            check($sformatf("rand%0d.yorder", i), 32'(y1 < y2), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
